cm82_serial_adder: RTL and testbench

Sequential 2-bit-per-cycle adder built around the 2-bit carry slice used in the CM82 arithmetic benchmarks. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then iterates the slice over WIDTH/2 digit positions, LSB digit first, with the carry registered between digits. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits directly upstream of result consumers and replaces a WIDTH-bit ripple adder with one reused 2-bit slice.

---
 rtl/cm82_serial_adder_if.sv | 26 ++
 rtl/cm82_serial_adder.sv | 120 ++++++++++++
 tb/tb_cm82_serial_adder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cm82_serial_adder_if.sv
// Operand/result handshake bundle for the CM82 serial adder.
// master: the client that supplies operands and consumes results.
// slave:  the adder itself.
interface cm82_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/cm82_serial_adder.sv
// Sequential adder that reuses one 2-bit CM82 carry slice across WIDTH/2
// digit positions, LSB digit first, with the inter-digit carry registered.
// Operands arrive over an in_valid/in_ready handshake; the WIDTH-bit sum
// and carry-out leave over an out_valid/out_ready handshake.
module cm82_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   cm82_serial_adder_if.slave  bus,
   output logic                busy
);

   localparam int DIGITS = WIDTH / 2;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("cm82_serial_adder: WIDTH must be even and at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   // Slice signals
   logic             a0, a1, b0, b1;
   logic             s0, s1, c1, c2;
   logic [WIDTH-1:0] sum_next;

   // 2-bit carry slice on the low digit of the shift registers, plus the
   // sum register after shifting the new digit in from the MSB end.
   always_comb begin
      a0 = a_sh[0];
      a1 = a_sh[1];
      b0 = b_sh[0];
      b1 = b_sh[1];
      s0 = a0 ^ b0 ^ carry_q;
      c1 = (a0 & b0) | (a0 & carry_q) | (b0 & carry_q);
      s1 = a1 ^ b1 ^ c1;
      c2 = (a1 & b1) | (a1 & c1) | (b1 & c1);
      sum_next = sum_q >> 2;
      sum_next[WIDTH-1 -: 2] = {s1, s0};
   end

   // Control FSM with registered handshake outputs and the datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_sh        <= '0;
         b_sh        <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh       <= bus.in_a;
                  b_sh       <= bus.in_b;
                  carry_q    <= bus.in_cin;
                  cnt        <= '0;
                  state      <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               sum_q   <= sum_next;
               a_sh    <= a_sh >> 2;
               b_sh    <= b_sh >> 2;
               carry_q <= c2;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST_DIGIT) begin
                  state       <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = carry_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_cm82_serial_adder.sv
// Directed bench for cm82_serial_adder (WIDTH=8) followed by a random
// back-to-back stream checked against a scoreboard.
module tb_cm82_serial_adder;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   int n_assert = 0;
   int n_fail   = 0;

   cm82_serial_adder_if #(.WIDTH(WIDTH)) bus ();

   cm82_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation with out_ready high and check latency, busy and result.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_cin    = cin;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      check({tag, " in_ready_pre"}, 32'(bus.in_ready), 32'd1);
      tick();                                   // E0
      bus.in_valid = 1'b0;
      check({tag, " busy_e0"}, 32'(busy), 32'd1);
      check({tag, " in_ready_e0"}, 32'(bus.in_ready), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();                                // E1..E4
         check({tag, " busy_run"}, 32'(busy), (i < 4) ? 32'd1 : 32'd0);
         check({tag, " out_valid_run"}, 32'(bus.out_valid), (i == 4) ? 32'd1 : 32'd0);
      end
      check({tag, " sum"}, 32'(bus.out_sum), 32'(exp_sum));
      check({tag, " cout"}, 32'(bus.out_cout), 32'(exp_cout));
      tick();                                   // DONE -> IDLE
      check({tag, " out_valid_after"}, 32'(bus.out_valid), 32'd0);
      check({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
   endtask

   logic [8:0]  sb_q[$];
   logic [8:0]  exp9;
   logic [7:0]  ra, rb;
   logic        rc;
   logic        acc;
   int          n_acc, n_done, cyc;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset / idle
      for (int i = 0; i < 10; i++) begin
         check("idle out_valid", 32'(bus.out_valid), 32'd0);
         check("idle in_ready", 32'(bus.in_ready), 32'd1);
         check("idle out_sum", 32'(bus.out_sum), 32'h00);
         check("idle out_cout", 32'(bus.out_cout), 32'd0);
         check("idle busy", 32'(busy), 32'd0);
         tick();
      end

      // Directed additions
      run_op("5A+33+1", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
      run_op("FF+01+0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      run_op("00+00+0", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

      // Backpressure: 3C+4B+0 = 87, held for 7 cycles; stray in_valid ignored
      bus.in_a      = 8'h3C;
      bus.in_b      = 8'h4B;
      bus.in_cin    = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("bp out_valid_rise", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin
            bus.in_a     = 8'h11;
            bus.in_b     = 8'h22;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
         check("bp out_valid", 32'(bus.out_valid), 32'd1);
         check("bp sum", 32'(bus.out_sum), 32'h87);
         check("bp cout", 32'(bus.out_cout), 32'd0);
         check("bp in_ready", 32'(bus.in_ready), 32'd0);
         check("bp busy", 32'(busy), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bp release out_valid", 32'(bus.out_valid), 32'd0);
      check("bp release in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("bp no queued op", 32'(busy), 32'd0);
      check("bp no queued in_ready", 32'(bus.in_ready), 32'd1);

      // Reset during 2nd RUN cycle of 12+34
      bus.in_a     = 8'h12;
      bus.in_b     = 8'h34;
      bus.in_cin   = 1'b0;
      bus.in_valid = 1'b1;
      tick();                                   // E0
      bus.in_valid = 1'b0;
      tick();                                   // E1
      rst = 1'b1;
      tick();                                   // E2 with reset
      rst = 1'b0;
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst out_sum", 32'(bus.out_sum), 32'h00);
      for (int i = 0; i < 6; i++) begin
         check("rst out_valid", 32'(bus.out_valid), 32'd0);
         tick();
      end
      run_op("01+02+0", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

      // Random back-to-back stream
      n_acc  = 0;
      n_done = 0;
      cyc    = 0;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      bus.in_a = ra; bus.in_b = rb; bus.in_cin = rc;
      bus.in_valid = 1'b1;
      while (n_done < 200 && cyc < 6000) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               check("stream unexpected result", 32'd1, 32'd0);
            end else begin
               exp9 = sb_q.pop_front();
               check("stream sum", 32'(bus.out_sum), 32'(exp9[7:0]));
               check("stream cout", 32'(bus.out_cout), 32'(exp9[8]));
            end
            n_done++;
         end
         if (acc) begin
            sb_q.push_back({1'b0, ra} + {1'b0, rb} + {8'b0, rc});
            n_acc++;
         end
         tick();
         cyc++;
         if (acc) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            bus.in_a = ra; bus.in_b = rb; bus.in_cin = rc;
            bus.in_valid = (n_acc < 200);
         end
      end
      check("stream results", 32'(n_done), 32'd200);
      check("stream accepted", 32'(n_acc), 32'd200);
      check("stream scoreboard empty", 32'(sb_q.size()), 32'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("final out_valid", 32'(bus.out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
